mul_rep: RTL



---
 rtl/mul_rep.sv | 95 +++++++++
 1 files changed

// File: rtl/mul_rep.sv
// rtl/mul_rep.sv - repeated-addition multiplier, p = a*b (+ r when MUL_REM_EN is defined)
// Optional macro MUL_REM_EN adds port r and seeds p with r at the accepting edge.
module mul_rep #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MUL_REM_EN
    input  logic [WIDTH-1:0]     r,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   count;
    logic [WIDTH-1:0]   a_lat;
    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] p_init;

`ifdef MUL_REM_EN
    assign p_init = {{WIDTH{1'b0}}, r};
`else
    assign p_init = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Zero count costs one extra edge so latency is always b+1.
                if (count != '0) begin
                    step = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p     <= '0;
            count <= '0;
            a_lat <= '0;
        end else if (load) begin
            p     <= p_init;
            count <= b;
            a_lat <= a;
        end else if (step) begin
            p     <= p + {{WIDTH{1'b0}}, a_lat};
            count <= count - 1'b1;
        end
    end

endmodule
